// File: rtl/rect_plotter_pkg.sv
// Shared constants for the rectangle plotter: screen size, palette and FSM encodings.
package rect_plotter_pkg;

  // Visible area of the 160x120 VGA adapter
  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;

  // 3-bit palette used by the game datapath
  localparam logic [2:0] COLOUR_BLACK  = 3'b000;
  localparam logic [2:0] COLOUR_WHITE  = 3'b111;
  localparam logic [2:0] COLOUR_GREEN  = 3'b010;
  localparam logic [2:0] COLOUR_YELLOW = 3'b110;

  // Plotter FSM encodings (2-bit, legacy-compatible)
  typedef logic [1:0] plot_state_t;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DRAW = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/rect_plotter_raster_counter.sv
// 2-D column/row counter that walks a w x h rectangle, column offset inner.
// It exposes the offsets of the slot that follows the current one so the
// owner can register that pixel on the same edge the counter advances.
module raster_counter
  import rect_plotter_pkg::*;
#(
  parameter int X_W = 8,
  parameter int Y_W = 7
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           load,
  input  logic           en,
  input  logic [X_W-1:0] w,
  input  logic [Y_W-1:0] h,
  output logic [X_W-1:0] nxt_col,
  output logic [Y_W-1:0] nxt_row,
  output logic           last
);

  logic [X_W-1:0] col_q;
  logic [Y_W-1:0] row_q;
  logic           col_end;

  // Slot arithmetic: wrap the column at w-1 and step the row on wrap
  always_comb begin
    col_end = (col_q == (w - X_W'(1)));
    last    = col_end && (row_q == (h - Y_W'(1)));
    nxt_col = col_end ? '0 : (col_q + X_W'(1));
    nxt_row = col_end ? (row_q + Y_W'(1)) : row_q;
  end

  // Offset registers: cleared on reset and on load, stepped while enabled
  always_ff @(posedge clk) begin
    if (!resetn) begin
      col_q <= '0;
      row_q <= '0;
    end else if (load) begin
      col_q <= '0;
      row_q <= '0;
    end else if (en) begin
      col_q <= nxt_col;
      row_q <= nxt_row;
    end
  end

endmodule

// File: rtl/rect_plotter.sv
// Rectangle rasteriser: accepts one rectangle request, emits one pixel slot
// per clock to the VGA adapter with screen clipping, then pulses done.
module rect_plotter
  import rect_plotter_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [X_W-1:0]      req_x,
  input  logic [Y_W-1:0]      req_y,
  input  logic [X_W-1:0]      req_w,
  input  logic [Y_W-1:0]      req_h,
  input  logic [COLOUR_W-1:0] req_colour,
  output logic [X_W-1:0]      plot_x,
  output logic [Y_W-1:0]      plot_y,
  output logic [COLOUR_W-1:0] plot_colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  plot_state_t state_q, state_d;

  // Request fields captured at acceptance
  logic [X_W-1:0]      x0_q;
  logic [Y_W-1:0]      y0_q;
  logic [X_W-1:0]      w_q;
  logic [Y_W-1:0]      h_q;
  logic [COLOUR_W-1:0] colour_q;

  // Output registers
  logic [X_W-1:0]      plot_x_q;
  logic [Y_W-1:0]      plot_y_q;
  logic [COLOUR_W-1:0] plot_colour_q;
  logic                plot_q;

  logic           accept;
  logic           req_empty;
  logic           draw_advance;
  logic           pix_load;
  logic           pix_on;
  logic [X_W-1:0] nxt_col;
  logic [Y_W-1:0] nxt_row;
  logic           last;

  logic [X_W-1:0]      base_x, off_x;
  logic [Y_W-1:0]      base_y, off_y;
  logic [COLOUR_W-1:0] pix_colour;
  logic [X_W:0]        sum_x;
  logic [Y_W:0]        sum_y;

  assign accept       = req_valid && (state_q == ST_IDLE);
  assign req_empty    = (req_w == '0) || (req_h == '0);
  assign draw_advance = (state_q == ST_DRAW) && !last;
  // A new pixel is registered either for slot 0 at acceptance or for the
  // following slot while drawing; the final slot hands over to DONE instead.
  assign pix_load     = (accept && !req_empty) || draw_advance;

  raster_counter #(
    .X_W(X_W),
    .Y_W(Y_W)
  ) u_raster_counter (
    .clk     (clk),
    .resetn  (resetn),
    .load    (accept),
    .en      (draw_advance),
    .w       (w_q),
    .h       (h_q),
    .nxt_col (nxt_col),
    .nxt_row (nxt_row),
    .last    (last)
  );

  // Pixel source: slot 0 comes straight from the request so the first pixel
  // appears in the cycle right after acceptance; later slots use the latches.
  always_comb begin
    base_x     = x0_q;
    base_y     = y0_q;
    off_x      = nxt_col;
    off_y      = nxt_row;
    pix_colour = colour_q;
    if (accept) begin
      base_x     = req_x;
      base_y     = req_y;
      off_x      = '0;
      off_y      = '0;
      pix_colour = req_colour;
    end
  end

  // Sums carry one extra bit so that wrap-around past the coordinate width is
  // clipped rather than folded back onto the left/top of the screen.
  always_comb begin
    sum_x  = {1'b0, base_x} + {1'b0, off_x};
    sum_y  = {1'b0, base_y} + {1'b0, off_y};
    pix_on = (sum_x < (X_W+1)'(SCREEN_W)) && (sum_y < (Y_W+1)'(SCREEN_H));
  end

  // Next-state logic for IDLE -> DRAW/DONE -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = req_empty ? ST_DONE : ST_DRAW;
      ST_DRAW: if (last)   state_d = ST_DONE;
      ST_DONE:             state_d = ST_IDLE;
      default:             state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Request latches, loaded only on acceptance so later input changes are ignored
  always_ff @(posedge clk) begin
    if (!resetn) begin
      x0_q     <= '0;
      y0_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      colour_q <= '0;
    end else if (accept) begin
      x0_q     <= req_x;
      y0_q     <= req_y;
      w_q      <= req_w;
      h_q      <= req_h;
      colour_q <= req_colour;
    end
  end

  // Output registers: strobe only on-screen slots, hold coordinates otherwise
  always_ff @(posedge clk) begin
    if (!resetn) begin
      plot_q        <= 1'b0;
      plot_x_q      <= '0;
      plot_y_q      <= '0;
      plot_colour_q <= '0;
    end else begin
      plot_q <= pix_load && pix_on;
      if (pix_load) begin
        plot_x_q      <= sum_x[X_W-1:0];
        plot_y_q      <= sum_y[Y_W-1:0];
        plot_colour_q <= pix_colour;
      end
    end
  end

  assign plot        = plot_q;
  assign plot_x      = plot_x_q;
  assign plot_y      = plot_y_q;
  assign plot_colour = plot_colour_q;
  assign req_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_rect_plotter.sv
// Directed bench for rect_plotter: reset, raster order, clipping, empty
// rectangles, request holding and single-pixel latency.
module tb_rect_plotter;

  logic       clk = 1'b0;
  logic       resetn;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_x;
  logic [6:0] req_y;
  logic [7:0] req_w;
  logic [6:0] req_h;
  logic [2:0] req_colour;
  logic [7:0] plot_x;
  logic [6:0] plot_y;
  logic [2:0] plot_colour;
  logic       plot;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_err = 0;

  rect_plotter dut (
    .clk         (clk),
    .resetn      (resetn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_x       (req_x),
    .req_y       (req_y),
    .req_w       (req_w),
    .req_h       (req_h),
    .req_colour  (req_colour),
    .plot_x      (plot_x),
    .plot_y      (plot_y),
    .plot_colour (plot_colour),
    .plot        (plot),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int x, input int y, input int w, input int h, input int c);
    req_x      = 8'(x);
    req_y      = 7'(y);
    req_w      = 8'(w);
    req_h      = 7'(h);
    req_colour = 3'(c);
    req_valid  = 1'b1;
    tick();
    req_valid  = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    tick();
    tick();
    n_vec++;
    if ({req_ready, plot, busy, done, plot_x, plot_y, plot_colour} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0}) begin
      n_err++;
      $display("FAIL reset_state got ready=%b plot=%b busy=%b done=%b x=%0d y=%0d c=%0d exp ready=1 plot=0 busy=0 done=0 x=0 y=0 c=0",
               req_ready, plot, busy, done, plot_x, plot_y, plot_colour);
    end
    resetn = 1'b1;
    tick();
    // T1: reset for two cycles in the middle of a 4x4 draw
    issue(5, 5, 4, 4, 7);
    tick();
    n_vec++;
    if ({plot, plot_x, plot_y} !== {1'b1, 8'd6, 7'd5}) begin
      n_err++;
      $display("FAIL t1_drawing got plot=%b x=%0d y=%0d exp plot=1 x=6 y=5", plot, plot_x, plot_y);
    end
    resetn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++;
      if ({plot, req_ready, done, busy} !== {1'b0, 1'b1, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL t1_in_reset cyc=%0d got plot=%b ready=%b done=%b busy=%b exp plot=0 ready=1 done=0 busy=0",
                 i, plot, req_ready, done, busy);
      end
    end
    resetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_vec++;
      if ({plot, done, req_ready} !== {1'b0, 1'b0, 1'b1}) begin
        n_err++;
        $display("FAIL t1_after_reset cyc=%0d got plot=%b done=%b ready=%b exp plot=0 done=0 ready=1",
                 i, plot, done, req_ready);
      end
    end
  endtask

  task automatic test_raster_order;
    logic [7:0] ex;
    logic [6:0] ey;
    issue(10, 20, 3, 2, 6);
    for (int k = 0; k < 6; k++) begin
      ex = 8'(10 + k % 3);
      ey = 7'(20 + k / 3);
      n_vec++;
      if ({plot, plot_x, plot_y, plot_colour, busy, done, req_ready} !== {1'b1, ex, ey, 3'b110, 1'b1, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL t2_pixel slot=%0d got plot=%b x=%0d y=%0d c=%0d busy=%b done=%b ready=%b exp plot=1 x=%0d y=%0d c=6 busy=1 done=0 ready=0",
                 k, plot, plot_x, plot_y, plot_colour, busy, done, req_ready, ex, ey);
      end
      tick();
    end
    n_vec++;
    if ({done, plot, busy, req_ready, plot_x, plot_y} !== {1'b1, 1'b0, 1'b1, 1'b0, 8'd12, 7'd21}) begin
      n_err++;
      $display("FAIL t2_done got done=%b plot=%b busy=%b ready=%b x=%0d y=%0d exp done=1 plot=0 busy=1 ready=0 x=12 y=21",
               done, plot, busy, req_ready, plot_x, plot_y);
    end
    tick();
    n_vec++;
    if ({done, busy, req_ready} !== {1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL t2_idle got done=%b busy=%b ready=%b exp done=0 busy=0 ready=1", done, busy, req_ready);
    end
  endtask

  task automatic test_clip;
    logic [7:0] ex;
    logic [6:0] ey;
    logic       ep;
    // T3: bottom-right corner, only two pixels visible
    issue(158, 119, 4, 2, 7);
    for (int k = 0; k < 8; k++) begin
      ex = 8'(158 + k % 4);
      ey = 7'(119 + k / 4);
      ep = (k < 2);
      n_vec++;
      if ({plot, plot_x, plot_y, plot_colour, done} !== {ep, ex, ey, 3'd7, 1'b0}) begin
        n_err++;
        $display("FAIL t3_slot slot=%0d got plot=%b x=%0d y=%0d c=%0d done=%b exp plot=%b x=%0d y=%0d c=7 done=0",
                 k, plot, plot_x, plot_y, plot_colour, done, ep, ex, ey);
      end
      tick();
    end
    n_vec++;
    if ({done, plot} !== {1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL t3_done got done=%b plot=%b exp done=1 plot=0", done, plot);
    end
    tick();
    // Column sums run past 255: low bits wrap but nothing may be plotted
    issue(250, 10, 8, 1, 5);
    for (int k = 0; k < 8; k++) begin
      ex = 8'(250 + k);
      n_vec++;
      if ({plot, plot_x, plot_y} !== {1'b0, ex, 7'd10}) begin
        n_err++;
        $display("FAIL t3_wrap slot=%0d got plot=%b x=%0d y=%0d exp plot=0 x=%0d y=10", k, plot, plot_x, plot_y, ex);
      end
      tick();
    end
    n_vec++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL t3_wrap_done got done=%b exp done=1", done);
    end
    tick();
  endtask

  task automatic test_empty;
    issue(40, 30, 0, 5, 3);
    n_vec++;
    if ({done, plot, busy, req_ready, plot_x, plot_y, plot_colour} !== {1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 7'd10, 3'd5}) begin
      n_err++;
      $display("FAIL t4_w0_done got done=%b plot=%b busy=%b ready=%b x=%0d y=%0d c=%0d exp done=1 plot=0 busy=1 ready=0 x=1 y=10 c=5",
               done, plot, busy, req_ready, plot_x, plot_y, plot_colour);
    end
    tick();
    n_vec++;
    if ({done, plot, req_ready} !== {1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL t4_w0_idle got done=%b plot=%b ready=%b exp done=0 plot=0 ready=1", done, plot, req_ready);
    end
    issue(40, 30, 3, 0, 3);
    n_vec++;
    if ({done, plot} !== {1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL t4_h0_done got done=%b plot=%b exp done=1 plot=0", done, plot);
    end
    tick();
    n_vec++;
    if ({done, req_ready} !== {1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL t4_h0_idle got done=%b ready=%b exp done=0 ready=1", done, req_ready);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] ex;
    logic [6:0] ey;
    req_x      = 8'd30;
    req_y      = 7'd40;
    req_w      = 8'd2;
    req_h      = 7'd2;
    req_colour = 3'd1;
    req_valid  = 1'b1;
    tick();
    req_x      = 8'd99;
    req_colour = 3'd4;
    for (int k = 0; k < 4; k++) begin
      ex = 8'(30 + k % 2);
      ey = 7'(40 + k / 2);
      n_vec++;
      if ({plot, plot_x, plot_y, plot_colour, req_ready} !== {1'b1, ex, ey, 3'd1, 1'b0}) begin
        n_err++;
        $display("FAIL t5_first slot=%0d got plot=%b x=%0d y=%0d c=%0d ready=%b exp plot=1 x=%0d y=%0d c=1 ready=0",
                 k, plot, plot_x, plot_y, plot_colour, req_ready, ex, ey);
      end
      tick();
    end
    n_vec++;
    if ({done, req_ready, plot} !== {1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL t5_done got done=%b ready=%b plot=%b exp done=1 ready=0 plot=0", done, req_ready, plot);
    end
    tick();
    n_vec++;
    if ({done, req_ready, plot} !== {1'b0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL t5_idle got done=%b ready=%b plot=%b exp done=0 ready=1 plot=0", done, req_ready, plot);
    end
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ex = 8'(99 + k % 2);
      ey = 7'(40 + k / 2);
      n_vec++;
      if ({plot, plot_x, plot_y, plot_colour} !== {1'b1, ex, ey, 3'd4}) begin
        n_err++;
        $display("FAIL t5_second slot=%0d got plot=%b x=%0d y=%0d c=%0d exp plot=1 x=%0d y=%0d c=4",
                 k, plot, plot_x, plot_y, plot_colour, ex, ey);
      end
      tick();
    end
    n_vec++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL t5_second_done got done=%b exp done=1", done);
    end
    tick();
  endtask

  task automatic test_single;
    issue(0, 0, 1, 1, 2);
    n_vec++;
    if ({plot, plot_x, plot_y, plot_colour, done} !== {1'b1, 8'd0, 7'd0, 3'b010, 1'b0}) begin
      n_err++;
      $display("FAIL t6_pixel got plot=%b x=%0d y=%0d c=%0d done=%b exp plot=1 x=0 y=0 c=2 done=0",
               plot, plot_x, plot_y, plot_colour, done);
    end
    tick();
    n_vec++;
    if ({done, plot, req_ready} !== {1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL t6_done got done=%b plot=%b ready=%b exp done=1 plot=0 ready=0", done, plot, req_ready);
    end
    tick();
    n_vec++;
    if ({done, req_ready, busy} !== {1'b0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL t6_idle got done=%b ready=%b busy=%b exp done=0 ready=1 busy=0", done, req_ready, busy);
    end
  endtask

  initial begin
    resetn     = 1'b0;
    req_valid  = 1'b0;
    req_x      = '0;
    req_y      = '0;
    req_w      = '0;
    req_h      = '0;
    req_colour = '0;
    test_reset();
    test_raster_order();
    test_clip();
    test_empty();
    test_back_to_back();
    test_single();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
